my_soc: RTL and testbench

- Minimal debug SoC top: a JTAG TAP lets a host send bytes out of, and read bytes in from, an 8N1 UART.
- All logic runs on one clock, clk, with one asynchronous active-low reset, reset_n.
- The JTAG pins are oversampled in the clk domain; no logic is clocked by TCK.
- The APB clock/reset pins exist only for top-level pin compatibility and are functionally unused.

---
 rtl/my_soc.sv | 385 ++++++++++++++++++++++++++++++++++++++
 tb/tb_my_soc.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_soc.sv
// my_soc: debug SoC top. A JTAG TAP, oversampled in the clk domain, gives a
// host a path to transmit bytes on an 8N1 UART and to read back received
// bytes and status flags. Everything runs on clk with an async active-low reset.
`timescale 1ns/1ps
module my_soc #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [31:0] IDCODE       = 32'h1000_0001
) (
    input  logic clk,
    input  logic reset_n,
    input  logic apb_clk,
    input  logic apb_resetn,
    output logic uart_tx,
    input  logic uart_rx,
    input  logic TCK,
    input  logic TMS,
    input  logic TDI,
    output logic TDO
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [3:0] INSTR_IDCODE  = 4'h1;
    localparam logic [3:0] INSTR_UART_TX = 4'h2;
    localparam logic [3:0] INSTR_UART_RX = 4'h3;

    // Synchroniser reset values: uart_rx idles high, JTAG pins low.
    localparam logic [3:0] SYNC_RST = 4'b1000;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // The APB pins exist only for pin compatibility.
    logic unused_apb;
    assign unused_apb = apb_clk ^ apb_resetn;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [3:0] sync_in;
    logic [3:0] sync_meta_reg;
    logic [3:0] sync_reg;
    logic       tck_d_reg;
    logic       rx_d_reg;
    logic       tck_s, tms_s, tdi_s, rx_s;
    logic       tck_rise, tck_fall, rx_fall;

    assign sync_in = {uart_rx, TDI, TMS, TCK};
    assign tck_s   = sync_reg[0];
    assign tms_s   = sync_reg[1];
    assign tdi_s   = sync_reg[2];
    assign rx_s    = sync_reg[3];

    // Two-flop synchronisers plus one delay stage for TCK / uart_rx edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_reg <= SYNC_RST;
            sync_reg      <= SYNC_RST;
            tck_d_reg     <= 1'b0;
            rx_d_reg      <= 1'b1;
        end else begin
            sync_meta_reg <= sync_in;
            sync_reg      <= sync_meta_reg;
            tck_d_reg     <= tck_s;
            rx_d_reg      <= rx_s;
        end
    end

    assign tck_rise = tck_s & ~tck_d_reg;
    assign tck_fall = ~tck_s & tck_d_reg;
    assign rx_fall  = rx_d_reg & ~rx_s;

    // ------------------------------------------------------------------
    // TAP controller
    // ------------------------------------------------------------------
    tap_state_t tap_state_reg, tap_state_next;

    // TAP state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_state_reg <= TLR;
        end else begin
            tap_state_reg <= tap_state_next;
        end
    end

    // Standard 1149.1 transitions, taken only on a detected TCK rise.
    always_comb begin
        tap_state_next = tap_state_reg;
        if (tck_rise) begin
            case (tap_state_reg)
                TLR:      tap_state_next = tms_s ? TLR      : RTI;
                RTI:      tap_state_next = tms_s ? SEL_DR   : RTI;
                SEL_DR:   tap_state_next = tms_s ? SEL_IR   : CAP_DR;
                CAP_DR:   tap_state_next = tms_s ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR: tap_state_next = tms_s ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR: tap_state_next = tms_s ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: tap_state_next = tms_s ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR: tap_state_next = tms_s ? UPD_DR   : SHIFT_DR;
                UPD_DR:   tap_state_next = tms_s ? SEL_DR   : RTI;
                SEL_IR:   tap_state_next = tms_s ? TLR      : CAP_IR;
                CAP_IR:   tap_state_next = tms_s ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR: tap_state_next = tms_s ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR: tap_state_next = tms_s ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: tap_state_next = tms_s ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR: tap_state_next = tms_s ? UPD_IR   : SHIFT_IR;
                UPD_IR:   tap_state_next = tms_s ? SEL_DR   : RTI;
                default:  tap_state_next = TLR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // IR / DR datapath
    // ------------------------------------------------------------------
    logic [3:0]  ir_reg;
    logic [3:0]  ir_shift_reg;
    logic [31:0] dr_shift_reg;
    logic        tdo_reg;
    logic [31:0] dr_capture;
    logic [31:0] dr_shifted;
    logic        capture_rx;
    logic        update_tx;

    logic        tx_busy;
    logic        tx_ovf_reg;
    logic        rx_valid_reg;
    logic [7:0]  rx_data_reg;
    logic [7:0]  rx_shift_reg;
    logic        rx_done;

    assign capture_rx = tck_rise && (tap_state_reg == CAP_DR) && (ir_reg == INSTR_UART_RX);
    assign update_tx  = tck_fall && (tap_state_reg == UPD_DR) && (ir_reg == INSTR_UART_TX);

    // Capture value per instruction; a byte completing in the capture cycle
    // is the one reported, so the host never loses it to the clear.
    always_comb begin
        dr_capture = 32'h0;
        case (ir_reg)
            INSTR_IDCODE:  dr_capture = IDCODE;
            INSTR_UART_RX: dr_capture = {22'h0, tx_ovf_reg,
                                         rx_done | rx_valid_reg,
                                         rx_done ? rx_shift_reg : rx_data_reg};
            default:       dr_capture = 32'h0;
        endcase
    end

    // Right shift of the selected DR with TDI entering at its MSB.
    always_comb begin
        dr_shifted = {31'h0, tdi_s};
        case (ir_reg)
            INSTR_IDCODE:  dr_shifted = {tdi_s, dr_shift_reg[31:1]};
            INSTR_UART_TX: dr_shifted = {24'h0, tdi_s, dr_shift_reg[7:1]};
            INSTR_UART_RX: dr_shifted = {22'h0, tdi_s, dr_shift_reg[9:1]};
            default:       dr_shifted = {31'h0, tdi_s};
        endcase
    end

    // Capture/shift on TCK rise, IR update and TDO launch on TCK fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_reg       <= INSTR_IDCODE;
            ir_shift_reg <= 4'b0001;
            dr_shift_reg <= 32'h0;
            tdo_reg      <= 1'b0;
        end else begin
            if (tap_state_reg == TLR) begin
                ir_reg <= INSTR_IDCODE;
            end else if (tck_fall && (tap_state_reg == UPD_IR)) begin
                ir_reg <= ir_shift_reg;
            end
            if (tck_rise) begin
                case (tap_state_reg)
                    CAP_IR:   ir_shift_reg <= 4'b0001;
                    SHIFT_IR: ir_shift_reg <= {tdi_s, ir_shift_reg[3:1]};
                    CAP_DR:   dr_shift_reg <= dr_capture;
                    SHIFT_DR: dr_shift_reg <= dr_shifted;
                    default:  ;
                endcase
            end
            if (tck_fall) begin
                if (tap_state_reg == SHIFT_IR) begin
                    tdo_reg <= ir_shift_reg[0];
                end else if (tap_state_reg == SHIFT_DR) begin
                    tdo_reg <= dr_shift_reg[0];
                end else begin
                    tdo_reg <= 1'b0;
                end
            end
        end
    end

    assign TDO = tdo_reg;

    // Status flags and received byte; setting always beats the capture clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_ovf_reg   <= 1'b0;
            rx_valid_reg <= 1'b0;
            rx_data_reg  <= 8'h0;
        end else begin
            if (update_tx && tx_busy) begin
                tx_ovf_reg <= 1'b1;
            end else if (capture_rx) begin
                tx_ovf_reg <= 1'b0;
            end
            if (rx_done) begin
                rx_valid_reg <= 1'b1;
                rx_data_reg  <= rx_shift_reg;
            end else if (capture_rx) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    tx_state_t        tx_state_reg, tx_state_next;
    logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]       tx_bit_reg, tx_bit_next;
    logic [7:0]       tx_shift_reg, tx_shift_next;
    logic             tx_line_reg, tx_line_next;
    logic             tx_req;

    assign tx_busy = (tx_state_reg != TX_IDLE);
    assign tx_req  = update_tx && !tx_busy;

    // Transmitter state register; the line is registered so it never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'h0;
            tx_line_reg  <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_line_reg  <= tx_line_next;
        end
    end

    // Frame sequencing: start, eight data bits LSB first, stop.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_line_next  = tx_line_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_line_next = 1'b1;
                if (tx_req) begin
                    tx_state_next = TX_START;
                    tx_cnt_next   = '0;
                    tx_shift_next = dr_shift_reg[7:0];
                    tx_line_next  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == CNT_MAX) begin
                    tx_state_next = TX_DATA;
                    tx_cnt_next   = '0;
                    tx_bit_next   = 3'd0;
                    tx_line_next  = tx_shift_reg[0];
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == CNT_MAX) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = TX_STOP;
                        tx_line_next  = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_line_next  = tx_shift_reg[1];
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_reg == CNT_MAX) begin
                    tx_state_next = TX_IDLE;
                    tx_cnt_next   = '0;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign uart_tx = tx_line_reg;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]       rx_bit_reg, rx_bit_next;
    logic [7:0]       rx_shift_next;

    // Receiver state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'h0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    // Mid-bit sampling: half a bit to re-check the start, then whole bits.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_done       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_next = RX_START;
                    rx_cnt_next   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_reg == HALF_MAX) begin
                    rx_cnt_next = '0;
                    if (!rx_s) begin
                        rx_state_next = RX_DATA;
                        rx_bit_next   = 3'd0;
                    end else begin
                        rx_state_next = RX_IDLE;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == CNT_MAX) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_s, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 3'd1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == CNT_MAX) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_IDLE;
                    rx_done       = rx_s;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_my_soc.sv
// tb_my_soc: directed bench for my_soc. JTAG DR accesses are driven from a
// vector table; UART frames, reset abort and flag behaviour are hand sequences.
`timescale 1ns/1ps
module tb_my_soc;

    localparam int CPB = 868;
    localparam logic [31:0] ID = 32'h1000_0001;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic apb_clk = 1'b0;
    logic apb_resetn = 1'b1;
    logic uart_tx;
    logic uart_rx = 1'b1;
    logic TCK = 1'b0;
    logic TMS = 1'b0;
    logic TDI = 1'b0;
    logic TDO;

    int tests = 0;
    int failures = 0;

    int unsigned cyc = 0;
    int unsigned tx_fall_cyc = 0;
    int unsigned tx_rise_cyc = 0;
    logic tx_prev_n = 1'b1;

    my_soc dut (
        .clk(clk), .reset_n(reset_n), .apb_clk(apb_clk), .apb_resetn(apb_resetn),
        .uart_tx(uart_tx), .uart_rx(uart_rx),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Timestamps of uart_tx edges, seen on the falling clock edge.
    always @(negedge clk) begin
        tx_prev_n <= uart_tx;
        if (tx_prev_n && !uart_tx) tx_fall_cyc <= cyc;
        if (!tx_prev_n && uart_tx) tx_rise_cyc <= cyc;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
        TMS = tms_v;
        TDI = tdi_v;
        repeat (4) @(posedge clk);
        TCK = 1'b1;
        repeat (HALF) @(posedge clk);
        TCK = 1'b0;
        repeat (HALF) @(posedge clk);
        @(negedge clk);
        tdo_v = TDO;
    endtask

    // Starts in Capture-xR; ends in Run-Test/Idle after the update.
    task automatic shift_reg(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic s;
        dout = '0;
        tck_cycle(1'b0, 1'b0, s);
        dout[0] = s;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], s);
            if (i < n - 1) dout[i+1] = s;
        end
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
    endtask

    task automatic load_ir(input logic [3:0] v, input string name);
        logic s;
        logic [31:0] d;
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        shift_reg(4, {28'h0, v}, d);
        check({name, "_ircap"}, {28'h0, d[3:0]}, 32'h1);
    endtask

    task automatic read_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic s;
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        shift_reg(n, din, dout);
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop_v);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx = stop_v;
        repeat (CPB) @(posedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    // Locates the start bit, then samples all ten bits at mid-bit.
    task automatic check_tx_frame(input logic [7:0] b, input string name);
        int n;
        int unsigned t0;
        logic [9:0] got;
        n = 0;
        while (uart_tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check({name, "_start_seen"}, 32'(n < 3000), 32'h1);
        t0 = tx_fall_cyc;
        got = '0;
        for (int k = 0; k < 10; k++) begin
            while (cyc < t0 + CPB * k + CPB / 2) @(negedge clk);
            got[k] = uart_tx;
            if (k == 1 && b[0]) begin
                #1;
                check({name, "_start_len"}, tx_rise_cyc - t0, CPB);
            end
        end
        check({name, "_frame"}, {22'h0, got}, {22'h0, 1'b1, b, 1'b0});
    endtask

    typedef struct {
        logic [3:0]  ir;
        int          len;
        logic [31:0] din;
        logic [31:0] exp;
    } jvec_t;

    jvec_t vecs [5];

    initial begin
        logic s;
        logic [31:0] d;
        int bad;
        int unsigned t0;

        vecs[0] = '{4'h1, 32, 32'h0000_0000, ID};
        vecs[1] = '{4'hF, 3,  32'h0000_0005, 32'h0000_0002};
        vecs[2] = '{4'h7, 4,  32'h0000_000F, 32'h0000_000E};
        vecs[3] = '{4'h1, 32, 32'hFFFF_FFFF, ID};
        vecs[4] = '{4'h3, 10, 32'h0000_0000, 32'h0000_0000};

        // Reset pulse and idle lines.
        #2 reset_n = 1'b0;
        #1;
        check("reset_uart_tx", 32'(uart_tx), 32'h1);
        check("reset_tdo", 32'(TDO), 32'h0);
        #9 reset_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || TDO !== 1'b0) bad++;
        end
        check("idle_lines_bad_samples", bad, 0);

        // IDCODE straight out of reset.
        tck_cycle(1'b0, 1'b0, s);
        read_dr(32, 32'h0, d);
        check("idcode_after_reset", d, ID);

        // Table of DR accesses.
        for (int i = 0; i < 5; i++) begin
            load_ir(vecs[i].ir, $sformatf("vec%0d", i));
            read_dr(vecs[i].len, vecs[i].din, d);
            check($sformatf("vec%0d_ir%0h_dr", i, vecs[i].ir), d, vecs[i].exp);
        end

        // Five TMS=1 from Shift-IR reaches Test-Logic-Reset, IR back to IDCODE.
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        repeat (5) tck_cycle(1'b1, 1'b0, s);
        check("tdo_in_tlr", 32'(s), 32'h0);
        tck_cycle(1'b0, 1'b0, s);
        read_dr(32, 32'h0, d);
        check("idcode_after_tms_reset", d, ID);

        // UART_TX of 0xA5.
        load_ir(4'h2, "tx_a5");
        fork
            check_tx_frame(8'hA5, "tx_a5");
            read_dr(8, 32'hA5, d);
        join
        repeat (1000) @(posedge clk);

        // UART_RX: good frame, then capture twice.
        uart_send(8'h3C, 1'b1);
        load_ir(4'h3, "rx_3c");
        read_dr(10, 32'h0, d);
        check("rx_capture_first", d, 32'h13C);
        read_dr(10, 32'h0, d);
        check("rx_capture_second", d, 32'h03C);

        // Start-bit glitch is ignored.
        uart_rx = 1'b0;
        repeat (200) @(posedge clk);
        uart_rx = 1'b1;
        repeat (1500) @(posedge clk);
        read_dr(10, 32'h0, d);
        check("rx_after_glitch", d, 32'h03C);

        // Framing error discards the byte.
        uart_send(8'h99, 1'b0);
        read_dr(10, 32'h0, d);
        check("rx_after_framing_err", d, 32'h03C);

        // Second TX while busy is dropped and sets tx_ovf.
        load_ir(4'h2, "tx_ovf");
        fork
            check_tx_frame(8'h11, "tx_11");
            begin
                read_dr(8, 32'h11, d);
                read_dr(8, 32'h22, d);
                load_ir(4'h3, "ovf_rd");
                read_dr(10, 32'h0, d);
                check("rx_reg_ovf_set", d, 32'h23C);
                read_dr(10, 32'h0, d);
                check("rx_reg_ovf_cleared", d, 32'h03C);
            end
        join
        repeat (1000) @(posedge clk);

        // Reset halfway through a frame.
        load_ir(4'h2, "tx_abort");
        read_dr(8, 32'hA5, d);
        #1;
        t0 = tx_fall_cyc;
        while (cyc < t0 + 5 * CPB + 100) @(negedge clk);
        check("mid_frame_bit4_low", 32'(uart_tx), 32'h0);
        #1 reset_n = 1'b0;
        #1;
        check("abort_uart_tx_high", 32'(uart_tx), 32'h1);
        check("abort_tdo_low", 32'(TDO), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) bad++;
        end
        check("abort_stays_high", bad, 0);
        tck_cycle(1'b0, 1'b0, s);
        read_dr(32, 32'h0, d);
        check("idcode_after_abort", d, ID);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
